// File: rtl/npc_pkg.sv
// Shared decode constants and types for the next-PC redirect unit.
// Opcode/funct values follow the MIPS encoding used by the core.
package npc_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] FN_JR     = 6'h08;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } npc_state_t;

  typedef struct packed {
    logic jr;
    logic j;
    logic br;
    logic taken;
  } npc_dec_t;

  function automatic npc_dec_t npc_decode(
    input logic [5:0]  op,
    input logic [5:0]  funct,
    input logic [31:0] aluout
  );
    npc_dec_t d;
    d.jr    = (op == OP_RTYPE) && (funct == FN_JR);
    d.j     = (op == OP_J) || (op == OP_JAL);
    d.br    = (op == OP_BEQ) || (op == OP_BNE)
           || (op == OP_REGIMM);
    d.taken = d.br && (
                ((op == OP_BEQ) && (aluout == 32'd0))
             || ((op == OP_BNE) && (aluout != 32'd0))
             || ((op == OP_REGIMM) && (aluout == 32'd1)));
    return d;
  endfunction

endpackage

// File: rtl/npc_stat_counter.sv
// Branch statistics counter with synchronous clear.
// At all-ones it either sticks or rolls over to zero.
module npc_stat_counter #(
  parameter int CW       = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] ONE = CW'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      if (&count) begin
        count <= SATURATE ? count : '0;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/npc_redirect_unit.sv
// Next-PC select and redirect/flush control at the IF/ID boundary,
// with accepted-branch statistics.
module npc_redirect_unit
  import npc_pkg::*;
#(
  parameter int AW           = 32,
  parameter int CW           = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter bit SATURATE     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pcen,
  input  logic [5:0]    op,
  input  logic [5:0]    funct,
  input  logic [AW-1:0] pc,
  input  logic [31:0]   aluout,
  input  logic [25:0]   label,
  input  logic [AW-1:0] rfd1,
  input  logic          stat_clr,
  output logic [AW-1:0] newpc,
  output logic          redirect,
  output logic          pcclear,
  output logic [CW-1:0] uncondsum,
  output logic [CW-1:0] condsum,
  output logic [CW-1:0] condsuccsum
);

  localparam logic [AW-1:0] FOUR    = AW'(4);
  localparam logic [AW-1:0] HI_MASK = ~AW'(28'hFFF_FFFF);
  localparam logic [2:0]    FC_LOAD = 3'(FLUSH_CYCLES - 1);

  npc_state_t    state;
  npc_state_t    state_n;
  logic [2:0]    fcnt;
  logic [2:0]    fcnt_n;
  npc_dec_t      dec;
  logic          acc;
  logic [AW-1:0] seq;
  logic [AW-1:0] j_tgt;
  logic [AW-1:0] br_off;
  logic [AW-1:0] br_tgt;

  assign dec = npc_decode(op, funct, aluout);
  assign acc = pcen && (state == ST_IDLE);

  // j keeps the top four bits of the delay-slot PC
  assign seq    = pc + FOUR;
  assign j_tgt  = (seq & HI_MASK) | AW'({label, 2'b00});
  assign br_off = {{(AW-18){label[15]}}, label[15:0], 2'b00};
  assign br_tgt = seq + br_off;

  always_comb begin
    newpc = seq;
    unique case (1'b1)
      acc && dec.jr:              newpc = rfd1;
      acc && dec.j:               newpc = j_tgt;
      acc && dec.br && dec.taken: newpc = br_tgt;
      default:                    newpc = seq;
    endcase
  end

  assign redirect = acc && (dec.jr || dec.j || dec.taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      fcnt  <= 3'd0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  // a stall while flushing freezes the countdown
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    unique case (state)
      ST_IDLE: begin
        if (redirect) begin
          state_n = ST_FLUSH;
          fcnt_n  = FC_LOAD;
        end
      end
      ST_FLUSH: begin
        if (pcen) begin
          if (fcnt == 3'd0) begin
            state_n = ST_IDLE;
          end else begin
            fcnt_n = fcnt - 3'd1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        fcnt_n  = 3'd0;
      end
    endcase
  end

  always_comb begin
    pcclear = (state == ST_FLUSH);
  end

  npc_stat_counter #(
    .CW       (CW),
    .SATURATE (SATURATE)
  ) u_uncond (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (acc && (dec.jr || dec.j)),
    .count (uncondsum)
  );

  npc_stat_counter #(
    .CW       (CW),
    .SATURATE (SATURATE)
  ) u_cond (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (acc && dec.br),
    .count (condsum)
  );

  npc_stat_counter #(
    .CW       (CW),
    .SATURATE (SATURATE)
  ) u_succ (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (acc && dec.br && dec.taken),
    .count (condsuccsum)
  );

endmodule

// File: tb/tb_npc_redirect_unit.sv
// Directed scoreboard bench for npc_redirect_unit across
// default, long-flush and narrow saturate/wrap configurations.
module tb_npc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcen;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] aluout;
  logic [25:0] label;
  logic [31:0] rfd1;
  logic        stat_clr;

  logic [31:0] a_newpc, b_newpc, c_newpc, f_newpc;
  logic        a_redir, b_redir, c_redir, f_redir;
  logic        a_clr, b_clr, c_clr, f_clr;
  logic [15:0] a_u, a_c, a_s, f_u, f_c, f_s;
  logic [3:0]  b_u, b_c, b_s, c_u, c_c, c_s;

  always #5 clk = ~clk;

  npc_redirect_unit u_a (
    .clk(clk), .rst(rst), .pcen(pcen), .op(op), .funct(funct),
    .pc(pc), .aluout(aluout), .label(label), .rfd1(rfd1),
    .stat_clr(stat_clr), .newpc(a_newpc), .redirect(a_redir),
    .pcclear(a_clr), .uncondsum(a_u), .condsum(a_c),
    .condsuccsum(a_s)
  );

  npc_redirect_unit #(.CW(4), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst(rst), .pcen(pcen), .op(op), .funct(funct),
    .pc(pc), .aluout(aluout), .label(label), .rfd1(rfd1),
    .stat_clr(stat_clr), .newpc(b_newpc), .redirect(b_redir),
    .pcclear(b_clr), .uncondsum(b_u), .condsum(b_c),
    .condsuccsum(b_s)
  );

  npc_redirect_unit #(.CW(4), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .pcen(pcen), .op(op), .funct(funct),
    .pc(pc), .aluout(aluout), .label(label), .rfd1(rfd1),
    .stat_clr(stat_clr), .newpc(c_newpc), .redirect(c_redir),
    .pcclear(c_clr), .uncondsum(c_u), .condsum(c_c),
    .condsuccsum(c_s)
  );

  npc_redirect_unit #(.FLUSH_CYCLES(3)) u_f (
    .clk(clk), .rst(rst), .pcen(pcen), .op(op), .funct(funct),
    .pc(pc), .aluout(aluout), .label(label), .rfd1(rfd1),
    .stat_clr(stat_clr), .newpc(f_newpc), .redirect(f_redir),
    .pcclear(f_clr), .uncondsum(f_u), .condsum(f_c),
    .condsuccsum(f_s)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_high;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic set_br(input logic [31:0] alu);
    op     = 6'h04;
    funct  = 6'h00;
    aluout = alu;
    label  = 26'h000FFFE;
    pc     = 32'h0000_3010;
  endtask

  task automatic set_j();
    op    = 6'h02;
    funct = 6'h00;
    label = 26'h0000C40;
    pc    = 32'h0000_3000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    pcen     = 1'b1;
    op       = 6'h00;
    funct    = 6'h00;
    pc       = 32'h0000_3000;
    aluout   = 32'd0;
    label    = 26'd0;
    rfd1     = 32'd0;
    stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    push("rst_newpc", 32'h3004);
    push("rst_redirect", 0);
    push("rst_pcclear", 0);
    push("rst_uncond", 0);
    push("rst_cond", 0);
    push("rst_succ", 0);
    #1;
    check(a_newpc); check(a_redir); check(a_clr);
    check(a_u); check(a_c); check(a_s);

    @(negedge clk);
    set_br(32'd0);
    push("beq_t_newpc", 32'h300C);
    push("beq_t_redirect", 1);
    #1;
    check(a_newpc); check(a_redir);
    push("beq_t_pcclear", 1);
    push("beq_t_cond", 1);
    push("beq_t_succ", 1);
    tick();
    check(a_clr); check(a_c); check(a_s);

    @(negedge clk);
    op = 6'h00;
    push("flush1_end", 0);
    tick();
    check(a_clr);

    @(negedge clk);
    set_br(32'd5);
    push("beq_nt_newpc", 32'h3014);
    push("beq_nt_redirect", 0);
    #1;
    check(a_newpc); check(a_redir);
    push("beq_nt_cond", 2);
    push("beq_nt_succ", 1);
    push("beq_nt_pcclear", 0);
    tick();
    check(a_c); check(a_s); check(a_clr);

    @(negedge clk);
    set_j();
    push("j_newpc", 32'h3100);
    push("j_redirect", 1);
    #1;
    check(a_newpc); check(a_redir);
    push("j_uncond", 1);
    push("j_pcclear", 1);
    tick();
    check(a_u); check(a_clr);

    @(negedge clk);
    set_br(32'd0);
    push("shadow_newpc", 32'h3014);
    push("shadow_redirect", 0);
    #1;
    check(a_newpc); check(a_redir);
    push("shadow_cond", 2);
    push("shadow_succ", 1);
    push("shadow_pcclear", 0);
    tick();
    check(a_c); check(a_s); check(a_clr);

    @(negedge clk);
    set_j();
    push("abort_pre_pcclear", 1);
    tick();
    check(a_clr);
    @(negedge clk);
    rst = 1'b1;
    op  = 6'h00;
    push("abort_pcclear", 0);
    push("abort_uncond", 0);
    push("abort_cond", 0);
    tick();
    check(a_clr); check(a_u); check(a_c);
    @(negedge clk);
    rst = 1'b0;
    set_br(32'd0);
    push("post_rst_redirect", 1);
    push("post_rst_newpc", 32'h300C);
    #1;
    check(a_redir); check(a_newpc);
    push("post_rst_pcclear", 1);
    push("post_rst_cond", 1);
    tick();
    check(a_clr); check(a_c);

    @(negedge clk);
    rst = 1'b1;
    op  = 6'h00;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    funct = 6'h08;
    rfd1  = 32'h0000_4000;
    pc    = 32'h0000_3000;
    push("jr_newpc", 32'h4000);
    push("jr_redirect", 1);
    #1;
    check(f_newpc); check(f_redir);
    tick();
    n_high = f_clr ? 1 : 0;
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      funct = 6'h00;
      pcen  = !(k == 2 || k == 3);
      tick();
      if (f_clr) n_high++;
      else break;
    end
    pcen = 1'b1;
    push("stall_flush_len", 5);
    push("stall_flush_end", 0);
    push("jr_uncond", 1);
    check(n_high); check(f_clr); check(f_u);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_j();
      @(posedge clk);
      @(negedge clk);
      op = 6'h00;
      @(posedge clk);
    end
    #1;
    push("sat_uncond", 32'hF);
    push("wrap_uncond", 32'h4);
    push("wide_uncond", 32'd20);
    push("sat_cond", 0);
    check(b_u); check(c_u); check(a_u); check(b_c);

    @(negedge clk);
    set_j();
    stat_clr = 1'b1;
    push("clr_sat", 0);
    push("clr_wrap", 0);
    push("clr_wide", 0);
    tick();
    check(b_u); check(c_u); check(a_u);
    stat_clr = 1'b0;
    op       = 6'h00;

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
